// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default bit period and frame line levels.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10417;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clr is high, so a bit period starts cleanly on release.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, DATA_W data bits LSB-first, stop bit.
// TX, busy and done are all registered so the pad never sees combinational glitches.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              TX,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    uart_state_t       state;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_idx;
    logic              tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            TX        <= STOP_BIT;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && tx_en) begin
                        shift_reg <= data;
                        state     <= START;
                        TX        <= START_BIT;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        TX      <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                            TX    <= STOP_BIT;
                        end else begin
                            // Drive the next bit directly so TX stays a pure flop output.
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + 1'b1;
                            TX        <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    TX    <= STOP_BIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
